matrix_sequencer: RTL and testbench

MATRIX_SEQUENCER -- requirements
Module: matrix_sequencer

---
 rtl/matrix_pkg.sv | 21 ++
 rtl/matrix_sequencer.sv | 136 +++++++++++++
 tb/tb_matrix_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared state encoding and default sizing for the LED matrix sequencer.
package matrix_pkg;

    localparam int DEF_NUM_CHIPS  = 4;
    localparam int DEF_FRAME_BITS = 138;
    localparam int DEF_CMD_BITS   = 12;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CS_SETUP = 4'd1,
        ST_WR_LO    = 4'd2,
        ST_WR_HI    = 4'd3,
        ST_CS_HOLD  = 4'd4,
        ST_DONE     = 4'd5
    } state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/matrix_sequencer.sv
// Serial frame sequencer for daisy-selected LED driver chips.
// Broadcast command transfers are built only with MATRIX_CMD_MODE_EN defined.
module matrix_sequencer
    import matrix_pkg::*;
#(
    parameter int NUM_CHIPS  = DEF_NUM_CHIPS,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int CMD_BITS   = DEF_CMD_BITS,
    localparam int CW = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1,
    localparam int MAXB = imax(FRAME_BITS, CMD_BITS),
    localparam int BW = (MAXB > 1) ? $clog2(MAXB) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 abort,
    input  logic                 bit_in,
    output logic [CW-1:0]        chip_idx,
    output logic [BW-1:0]        bit_idx,
    output logic [NUM_CHIPS-1:0] cs_n,
    output logic                 wr_n,
    output logic                 data_out,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           dbg_state
);

    localparam logic [BW-1:0] DLAST = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] CLAST = BW'(CMD_BITS - 1);
    localparam logic [CW-1:0] CLAST_CHIP = CW'(NUM_CHIPS - 1);

    state_t        state, nstate;
    logic [CW-1:0] chip;
    logic [BW-1:0] cnt;
    logic [BW-1:0] last;
    logic          dout;
    logic          sel;

`ifdef MATRIX_CMD_MODE_EN
    logic cmd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cmd <= 1'b0;
        else if (state == ST_IDLE && start)
            cmd <= mode;
    end
`else
    logic cmd;
    logic unused_mode;

    assign cmd         = 1'b0;
    assign unused_mode = mode;
`endif

    assign last = cmd ? CLAST : DLAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= nstate;
    end

    // abort overrides every transition out of a busy state
    always_comb begin
        nstate = state;
        if (abort && state != ST_IDLE) begin
            nstate = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:     if (start) nstate = ST_CS_SETUP;
                ST_CS_SETUP: nstate = ST_WR_LO;
                ST_WR_LO:    nstate = ST_WR_HI;
                ST_WR_HI:    nstate = (cnt == last) ? ST_CS_HOLD : ST_WR_LO;
                ST_CS_HOLD:
                    nstate = (!cmd && chip != CLAST_CHIP) ? ST_CS_SETUP
                                                          : ST_DONE;
                ST_DONE:     nstate = ST_IDLE;
                default:     nstate = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chip <= '0;
            cnt  <= '0;
            dout <= 1'b0;
        end else if (nstate == ST_IDLE) begin
            chip <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    chip <= '0;
                    cnt  <= '0;
                end
                ST_CS_SETUP: dout <= bit_in;
                ST_WR_HI: begin
                    if (nstate == ST_WR_LO) begin
                        cnt  <= cnt + BW'(1);
                        dout <= bit_in;
                    end
                end
                ST_CS_HOLD: begin
                    cnt <= '0;
                    if (nstate == ST_CS_SETUP)
                        chip <= chip + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // during WR_HI the source is already addressed with the next bit
    assign bit_idx = (state == ST_WR_HI && cnt != last) ? cnt + BW'(1) : cnt;

    assign sel = (state == ST_CS_SETUP) || (state == ST_WR_LO) ||
                 (state == ST_WR_HI);

    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NUM_CHIPS; i++)
            cs_n[i] = ~(sel & (cmd | (chip == CW'(i))));
    end

    assign chip_idx  = chip;
    assign wr_n      = (state != ST_WR_LO);
    assign data_out  = dout;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_matrix_sequencer.sv
// Self-checking bench for matrix_sequencer: default build plus a 1-chip, 3-bit instance.
module tb_matrix_sequencer;
    import matrix_pkg::*;

    localparam int NC = 4;
    localparam int FB = 138;
    localparam int CB = 12;
    localparam int DATA_LAT = NC * (2 * FB + 2) + 1;
    localparam int CMD_LAT  = 2 * CB + 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       mode;
    logic       abort;
    logic       bit_in;
    logic [1:0] chip_idx;
    logic [7:0] bit_idx;
    logic [3:0] cs_n;
    logic       wr_n;
    logic       data_out;
    logic       busy;
    logic       done;
    logic [3:0] dbg_state;

    logic       s_start;
    logic       s_bit_in;
    logic [0:0] s_chip_idx;
    logic [3:0] s_bit_idx;
    logic [0:0] s_cs_n;
    logic       s_wr_n;
    logic       s_data_out;
    logic       s_busy;
    logic       s_done;
    logic [3:0] s_dbg_state;

    logic frames [NC][256];
    logic s_frame [16];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign bit_in   = frames[chip_idx][bit_idx];
    assign s_bit_in = s_frame[s_bit_idx];

    matrix_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .abort(abort), .bit_in(bit_in), .chip_idx(chip_idx),
        .bit_idx(bit_idx), .cs_n(cs_n), .wr_n(wr_n),
        .data_out(data_out), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    matrix_sequencer #(.NUM_CHIPS(1), .FRAME_BITS(3)) dut1 (
        .clk(clk), .reset(reset), .start(s_start), .mode(1'b0),
        .abort(1'b0), .bit_in(s_bit_in), .chip_idx(s_chip_idx),
        .bit_idx(s_bit_idx), .cs_n(s_cs_n), .wr_n(s_wr_n),
        .data_out(s_data_out), .busy(s_busy), .done(s_done),
        .dbg_state(s_dbg_state)
    );

    task automatic fill_random();
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < 256; b++)
                frames[c][b] = 1'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; s_start = 1'b0;
        fill_random();
        for (int b = 0; b < 16; b++) s_frame[b] = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({cs_n, wr_n, data_out, busy, done} !== {4'hF, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got cs=%b wr=%b d=%b busy=%b done=%b",
                     cs_n, wr_n, data_out, busy, done);
        end
        n_chk++;
        if (chip_idx !== 2'd0 || bit_idx !== 8'd0 || dbg_state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_index: chip=%0d bit=%0d st=%0d, want 0 0 0",
                     chip_idx, bit_idx, dbg_state);
        end
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_data_frame();
        int   cyc = 0, strobes = 0, done_cyc = -1, dones = 0, c, b;
        logic prev_wr = 1'b1;
        logic held = 1'b0;
        logic [3:0] exp_cs;
        fill_random();
        start = 1'b1;
        while (cyc < DATA_LAT + 50) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy === 1'b1 && $countones(~cs_n) > 1) begin
                n_chk++; n_fail++;
                $display("FAIL one_hot_cs: cycle %0d cs_n=%b", cyc, cs_n);
            end
            if (wr_n === 1'b0) begin
                c = strobes / FB;
                b = strobes % FB;
                n_chk++;
                if (c >= NC) begin
                    n_fail++;
                    $display("FAIL extra_strobe: strobe %0d beyond %0d", strobes, NC * FB);
                end else begin
                    exp_cs = ~(4'b0001 << c);
                    if (cs_n !== exp_cs || data_out !== frames[c][b]) begin
                        n_fail++;
                        $display("FAIL strobe c%0d b%0d: cs=%b d=%b, want cs=%b d=%b",
                                 c, b, cs_n, data_out, exp_cs, frames[c][b]);
                    end
                end
                held = data_out;
                strobes++;
            end else if (prev_wr === 1'b0) begin
                n_chk++;
                if (data_out !== held) begin
                    n_fail++;
                    $display("FAIL data_hold: cycle %0d d=%b, want %b", cyc, data_out, held);
                end
            end
            prev_wr = wr_n;
            if (done === 1'b1) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc > 0 && cyc > done_cyc + 3) break;
        end
        n_chk++;
        if (strobes != NC * FB) begin
            n_fail++;
            $display("FAIL strobe_count: got %0d, want %0d", strobes, NC * FB);
        end
        n_chk++;
        if (done_cyc != DATA_LAT) begin
            n_fail++;
            $display("FAIL data_latency: done at %0d, want %0d", done_cyc, DATA_LAT);
        end
        n_chk++;
        if (dones != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: %0d done cycles busy=%b, want 1 and 0", dones, busy);
        end
    endtask

    task automatic test_abort();
        int cyc = 0, hits = 0, dones = 0;
        fill_random();
        start = 1'b1;
        while (cyc < DATA_LAT && hits < 5) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (wr_n === 1'b0 && cs_n === 4'b1011) hits++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_chk++;
        if (hits != 5 || cs_n !== 4'hF || wr_n !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_exit: hits=%0d cs=%b wr=%b busy=%b, want 5 1111 1 0",
                     hits, cs_n, wr_n, busy);
        end
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy !== 1'b0) dones++;
        end
        n_chk++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d bad cycles, want 0", dones);
        end
    endtask

    task automatic test_async_reset();
        int cyc = 0, bad = 0;
        fill_random();
        start = 1'b1;
        while (cyc < 20 && wr_n !== 1'b0) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (wr_n !== 1'b0 && cyc >= 20) begin
            n_fail++;
            $display("FAIL async_setup: never reached WR_LO");
        end else if (cs_n !== 4'hF || wr_n !== 1'b1 || busy !== 1'b0 || data_out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: cs=%b wr=%b busy=%b d=%b, want 1111 1 0 0",
                     cs_n, wr_n, busy, data_out);
        end
        @(negedge clk) reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_discard: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0, d1 = -1, d2 = -1, strobes = 0, alt_err = 0;
        logic idle_gap = 1'b0, restart = 1'b0;
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < 256; b++)
                frames[c][b] = b[0];
        start = 1'b1;
        while (cyc < 2 * DATA_LAT + 20) begin
            @(negedge clk);
            cyc++;
            if (wr_n === 1'b0) begin
                if (data_out !== 1'((strobes % FB) % 2)) alt_err++;
                strobes++;
            end
            if (d1 > 0 && cyc == d1 + 1) idle_gap = (busy === 1'b0);
            if (d1 > 0 && cyc == d1 + 2) restart = (busy === 1'b1);
            if (done === 1'b1) begin
                if (d1 < 0) d1 = cyc;
                else if (d2 < 0) d2 = cyc;
            end
            if (d2 > 0) begin
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++;
        if (d1 != DATA_LAT || d2 != 2 * DATA_LAT + 1) begin
            n_fail++;
            $display("FAIL held_start_timing: done at %0d,%0d want %0d,%0d",
                     d1, d2, DATA_LAT, 2 * DATA_LAT + 1);
        end
        n_chk++;
        if (!idle_gap || !restart) begin
            n_fail++;
            $display("FAIL held_start_restart: gap=%b restart=%b, want 1 1", idle_gap, restart);
        end
        n_chk++;
        if (alt_err != 0 || strobes != 2 * NC * FB) begin
            n_fail++;
            $display("FAIL alternating_data: %0d errors %0d strobes, want 0 %0d",
                     alt_err, strobes, 2 * NC * FB);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_start_stop: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_mode();
        int   cyc = 0, strobes = 0, done_cyc = -1, bad = 0;
        fill_random();
        mode  = 1'b1;
        start = 1'b1;
        while (cyc < DATA_LAT + 20 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            mode  = 1'b0;
            if (wr_n === 1'b0) begin
`ifdef MATRIX_CMD_MODE_EN
                if (cs_n !== 4'b0000 || data_out !== frames[0][strobes]) bad++;
`else
                if (cs_n !== ~(4'b0001 << (strobes / FB)) ||
                    data_out !== frames[strobes / FB][strobes % FB]) bad++;
`endif
                strobes++;
            end
            if (done === 1'b1) done_cyc = cyc;
        end
        @(negedge clk);
`ifdef MATRIX_CMD_MODE_EN
        n_chk++;
        if (done_cyc != CMD_LAT || strobes != CB || bad != 0) begin
            n_fail++;
            $display("FAIL cmd_mode: done %0d strobes %0d bad %0d, want %0d %0d 0",
                     done_cyc, strobes, bad, CMD_LAT, CB);
        end
`else
        n_chk++;
        if (done_cyc != DATA_LAT || strobes != NC * FB || bad != 0) begin
            n_fail++;
            $display("FAIL mode_ignored: done %0d strobes %0d bad %0d, want %0d %0d 0",
                     done_cyc, strobes, bad, DATA_LAT, NC * FB);
        end
`endif
        n_chk++;
        if (cs_n !== 4'hF || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_end: cs=%b busy=%b, want 1111 0", cs_n, busy);
        end
    endtask

    task automatic test_single_chip();
        int   cyc = 0, strobes = 0, done_cyc = -1, chip_bad = 0;
        logic [2:0] seen = 3'b000;
        s_frame[0] = 1'b1; s_frame[1] = 1'b0; s_frame[2] = 1'b1;
        s_start = 1'b1;
        while (cyc < 30 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            s_start = 1'b0;
            if (s_chip_idx !== 1'b0) chip_bad++;
            if (s_wr_n === 1'b0 && strobes < 3) begin
                seen[2 - strobes] = s_data_out;
                strobes++;
            end
            if (s_done === 1'b1) done_cyc = cyc;
        end
        n_chk++;
        if (done_cyc != 9) begin
            n_fail++;
            $display("FAIL single_latency: done at %0d, want 9", done_cyc);
        end
        n_chk++;
        if (seen !== 3'b101 || strobes != 3) begin
            n_fail++;
            $display("FAIL single_data: got %b (%0d strobes), want 101 (3)", seen, strobes);
        end
        n_chk++;
        if (chip_bad != 0) begin
            n_fail++;
            $display("FAIL single_chip_idx: %0d nonzero cycles, want 0", chip_bad);
        end
        @(negedge clk);
        n_chk++;
        if (s_busy !== 1'b0 || s_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL single_end: busy=%b cs=%b, want 0 1", s_busy, s_cs_n);
        end
    endtask

    initial begin
        test_reset();
        test_data_frame();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_mode();
        test_single_chip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
